// File: rtl/mem_port_arbiter.sv
// Arbiter that time-shares one memory port between the I-cache refill path and the D-cache path.
// D-cache wins ties unless the I-cache has waited through MAX_D_STREAK D grants in a row.
module mem_port_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 2,
    parameter int MAX_D_STREAK = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              im_req,
    input  logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_rdata,
    output logic              im_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
    localparam int STREAK_W = (MAX_D_STREAK > 1) ? $clog2(MAX_D_STREAK + 1) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(MEM_LAT - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE = STREAK_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                owner_i_q, owner_i_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [STREAK_W-1:0] d_streak_q, d_streak_d;

    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                im_done_q, im_done_d;
    logic                dm_done_q, dm_done_d;
    logic [DATA_W-1:0]   im_rdata_q, im_rdata_d;
    logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;
    logic                busy_q, busy_d;

    // Next-state logic: arbitration, access sequencing and output look-ahead
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_i_d  = owner_i_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        d_streak_d = d_streak_q;

        case (state_q)
            ST_IDLE: begin
                if (im_req || dm_req) begin
                    state_d = ST_BUSY;
                    cnt_d   = {CNT_W{1'b0}};
                    // I wins when alone, or when D has used up its streak allowance
                    if (im_req && (!dm_req || (d_streak_q == STREAK_MAX))) begin
                        owner_i_d  = 1'b1;
                        we_d       = 1'b0;
                        addr_d     = im_addr;
                        wdata_d    = {DATA_W{1'b0}};
                        d_streak_d = {STREAK_W{1'b0}};
                    end else begin
                        owner_i_d = 1'b0;
                        we_d      = dm_we;
                        addr_d    = dm_addr;
                        wdata_d   = dm_wdata;
                        if (!im_req) begin
                            d_streak_d = {STREAK_W{1'b0}};
                        end else if (d_streak_q == STREAK_MAX) begin
                            d_streak_d = d_streak_q;
                        end else begin
                            d_streak_d = d_streak_q + STREAK_ONE;
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_RESP;
                    rdata_d = we_q ? {DATA_W{1'b0}} : mem_rdata;
                end else begin
                    state_d = ST_BUSY;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        mem_en_d    = (state_d == ST_BUSY);
        mem_we_d    = mem_en_d && we_d;
        mem_addr_d  = mem_en_d ? addr_d : {ADDR_W{1'b0}};
        mem_wdata_d = mem_we_d ? wdata_d : {DATA_W{1'b0}};
        busy_d      = (state_d != ST_IDLE);
        im_done_d   = (state_d == ST_RESP) && owner_i_d;
        dm_done_d   = (state_d == ST_RESP) && !owner_i_d;
        im_rdata_d  = im_done_d ? rdata_d : {DATA_W{1'b0}};
        dm_rdata_d  = dm_done_d ? rdata_d : {DATA_W{1'b0}};
    end

    // State and registered-output flops; reset drops any in-flight access
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            owner_i_q   <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            wdata_q     <= {DATA_W{1'b0}};
            rdata_q     <= {DATA_W{1'b0}};
            d_streak_q  <= {STREAK_W{1'b0}};
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            im_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            im_rdata_q  <= {DATA_W{1'b0}};
            dm_rdata_q  <= {DATA_W{1'b0}};
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_i_q   <= owner_i_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            d_streak_q  <= d_streak_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            im_done_q   <= im_done_d;
            dm_done_q   <= dm_done_d;
            im_rdata_q  <= im_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign im_done   = im_done_q;
    assign dm_done   = dm_done_q;
    assign im_rdata  = im_rdata_q;
    assign dm_rdata  = dm_rdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized run
// against a transaction-level timeline model of the arbiter.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 16;
    localparam int DATA_W       = 32;
    localparam int MEM_LAT      = 2;
    localparam int MAX_D_STREAK = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              im_req;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W-1:0] im_rdata;
    logic              im_done;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    int errors = 0;
    int checks = 0;
    int en_run;
    logic [116:0] outs_all;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .MAX_D_STREAK(MAX_D_STREAK)
    ) dut (
        .clk(clk), .rst(rst),
        .im_req(im_req), .im_addr(im_addr), .im_rdata(im_rdata), .im_done(im_done),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_done(dm_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign outs_all = {busy, mem_en, mem_we, mem_addr, mem_wdata, im_done, dm_done, im_rdata, dm_rdata};

    function automatic logic [31:0] mem_val(input logic [15:0] a);
        if (a == 16'h0010) return 32'h0000_0013;
        return {~a, a} ^ 32'h5A5A_3C3C;
    endfunction

    // Memory model: read data is valid only in the last cycle of an enable run
    always @(posedge clk or negedge rst) begin
        if (!rst) en_run <= 0;
        else      en_run <= mem_en ? en_run + 1 : 0;
    end
    assign mem_rdata = (mem_en && !mem_we && en_run == MEM_LAT - 1) ? mem_val(mem_addr) : 32'hBADB_AD00;

    task automatic idle_inputs();
        im_req = 1'b0; im_addr = 16'h0000;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0000; dm_wdata = 32'h0000_0000;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        im_req = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (outs_all !== 117'd0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", outs_all);
        end
        im_req = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0) begin
            errors++; $display("FAIL reset_release: busy=%b mem_en=%b want 0 0", busy, mem_en);
        end
    endtask

    task automatic test_i_read();
        logic exp_en;
        im_req = 1'b1; im_addr = 16'h0010;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_en = (c == 1 || c == 2);
            checks++;
            if (mem_en !== exp_en || (exp_en && (mem_addr !== 16'h0010 || mem_we !== 1'b0))) begin
                errors++;
                $display("FAIL t1_mem c=%0d: en=%b we=%b addr=%h want en=%b we=0 addr=0010", c, mem_en, mem_we, mem_addr, exp_en);
            end
            checks++;
            if (im_done !== (c == 3) || im_rdata !== ((c == 3) ? 32'h0000_0013 : 32'h0) || dm_done !== 1'b0) begin
                errors++;
                $display("FAIL t1_done c=%0d: im_done=%b im_rdata=%h dm_done=%b want %b %h 0", c, im_done, im_rdata, dm_done, (c == 3), ((c == 3) ? 32'h13 : 32'h0));
            end
            checks++;
            if (busy !== (c <= 3)) begin
                errors++; $display("FAIL t1_busy c=%0d: got %b want %b", c, busy, (c <= 3));
            end
            if (c == 3) im_req = 1'b0;
        end
    endtask

    task automatic test_d_write();
        logic exp_en;
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 16'h8000; dm_wdata = 32'hDEAD_BEEF;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            exp_en = (c == 1 || c == 2);
            checks++;
            if (mem_en !== exp_en || mem_we !== exp_en ||
                (exp_en && (mem_addr !== 16'h8000 || mem_wdata !== 32'hDEAD_BEEF))) begin
                errors++;
                $display("FAIL t2_mem c=%0d: en=%b we=%b addr=%h wdata=%h want en=we=%b addr=8000 wdata=deadbeef", c, mem_en, mem_we, mem_addr, mem_wdata, exp_en);
            end
            checks++;
            if (dm_done !== (c == 3) || dm_rdata !== 32'h0 || im_done !== 1'b0) begin
                errors++;
                $display("FAIL t2_done c=%0d: dm_done=%b dm_rdata=%h im_done=%b want %b 0 0", c, dm_done, dm_rdata, im_done, (c == 3));
            end
            if (c == 3) begin dm_req = 1'b0; dm_we = 1'b0; end
        end
    endtask

    task automatic test_simultaneous();
        logic exp_en;
        logic [15:0] exp_addr;
        im_req = 1'b1; im_addr = 16'h0040;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0100;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            exp_en   = (c == 1 || c == 2 || c == 5 || c == 6);
            exp_addr = (c <= 2) ? 16'h0100 : 16'h0040;
            checks++;
            if (mem_en !== exp_en || mem_we !== 1'b0 || (exp_en && mem_addr !== exp_addr)) begin
                errors++;
                $display("FAIL t3_mem c=%0d: en=%b we=%b addr=%h want en=%b we=0 addr=%h", c, mem_en, mem_we, mem_addr, exp_en, exp_addr);
            end
            checks++;
            if (dm_done !== (c == 3) || dm_rdata !== ((c == 3) ? mem_val(16'h0100) : 32'h0) ||
                im_done !== (c == 7) || im_rdata !== ((c == 7) ? mem_val(16'h0040) : 32'h0)) begin
                errors++;
                $display("FAIL t3_done c=%0d: dm=%b/%h im=%b/%h want dm=%b im=%b", c, dm_done, dm_rdata, im_done, im_rdata, (c == 3), (c == 7));
            end
            if (c == 3) dm_req = 1'b0;
            if (c == 7) im_req = 1'b0;
        end
    endtask

    task automatic test_starvation();
        bit got[$];
        bit exp_order[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        im_req = 1'b1; im_addr = 16'($urandom);
        dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_addr = 16'($urandom); dm_wdata = $urandom;
        for (int c = 0; c < 60 && got.size() < 6; c++) begin
            @(negedge clk);
            if (dm_done) begin
                got.push_back(1'b0);
                dm_we = 1'($urandom_range(0, 1)); dm_addr = 16'($urandom); dm_wdata = $urandom;
            end
            if (im_done) begin
                got.push_back(1'b1);
                im_addr = 16'($urandom);
            end
            if (got.size() >= 6) begin im_req = 1'b0; dm_req = 1'b0; end
        end
        im_req = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++; $display("FAIL t4_order[%0d]: no grant seen want %s", i, exp_order[i] ? "I" : "D");
            end else if (got[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL t4_order[%0d]: got %s want %s", i, got[i] ? "I" : "D", exp_order[i] ? "I" : "D");
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0300;
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (outs_all !== 117'd0) begin
            errors++; $display("FAIL t5_async_clear: got %h want 0", outs_all);
        end
        dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if (dm_done !== 1'b0 || busy !== 1'b0 || mem_en !== 1'b0) begin
                errors++; $display("FAIL t5_no_done c=%0d: dm_done=%b busy=%b mem_en=%b want 0 0 0", c, dm_done, busy, mem_en);
            end
        end
        im_req = 1'b1; im_addr = 16'h0020;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            checks++;
            if (im_done !== (c == 3) || im_rdata !== ((c == 3) ? mem_val(16'h0020) : 32'h0) || busy !== (c <= 3)) begin
                errors++;
                $display("FAIL t5_after c=%0d: im_done=%b im_rdata=%h busy=%b want %b %h %b", c, im_done, im_rdata, busy, (c == 3), ((c == 3) ? mem_val(16'h0020) : 32'h0), (c <= 3));
            end
            if (c == 3) im_req = 1'b0;
        end
    endtask

    task automatic test_late_request();
        bit got[$];
        bit exp_order[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        im_req = 1'b1; im_addr = 16'h0030;
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 16'h0200;
        for (int c = 2; c < 60 && got.size() < 5; c++) begin
            @(negedge clk);
            if (c == 4) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++; $display("FAIL t6_idle_gap: busy=%b want 0", busy);
                end
            end
            if (c == 5) begin
                checks++;
                if (mem_en !== 1'b1 || mem_addr !== 16'h0200) begin
                    errors++; $display("FAIL t6_d_grant: mem_en=%b addr=%h want 1 0200", mem_en, mem_addr);
                end
            end
            if (im_done) begin
                got.push_back(1'b1);
                im_req = 1'b0;
            end
            if (dm_done) begin
                got.push_back(1'b0);
                im_req = 1'b1; im_addr = 16'($urandom);
                dm_addr = 16'($urandom);
            end
            if (got.size() >= 5) begin im_req = 1'b0; dm_req = 1'b0; end
        end
        im_req = 1'b0; dm_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (i >= got.size()) begin
                errors++; $display("FAIL t6_order[%0d]: no grant seen want %s", i, exp_order[i] ? "I" : "D");
            end else if (got[i] !== exp_order[i]) begin
                errors++;
                $display("FAIL t6_order[%0d]: got %s want %s", i, got[i] ? "I" : "D", exp_order[i] ? "I" : "D");
            end
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int ph = 0;
        int streak = 0;
        bit own_i = 1'b0;
        logic [15:0] t_addr = 16'h0;
        logic        t_we = 1'b0;
        logic [31:0] t_wdata = 32'h0;
        logic [31:0] t_rdata = 32'h0;
        logic exp_en, exp_i, exp_d;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            exp_en = (ph >= 1 && ph <= MEM_LAT);
            exp_i  = (ph == MEM_LAT + 1) && own_i;
            exp_d  = (ph == MEM_LAT + 1) && !own_i;
            checks++;
            if (busy !== (ph != 0)) begin
                errors++; $display("FAIL rnd_busy cyc=%0d: got %b want %b", cyc, busy, (ph != 0));
            end
            checks++;
            if (mem_en !== exp_en || mem_we !== (exp_en && t_we) || (exp_en && mem_addr !== t_addr) ||
                (exp_en && t_we && mem_wdata !== t_wdata)) begin
                errors++;
                $display("FAIL rnd_mem cyc=%0d: en=%b we=%b addr=%h wdata=%h want en=%b we=%b addr=%h wdata=%h", cyc, mem_en, mem_we, mem_addr, mem_wdata, exp_en, exp_en && t_we, t_addr, t_wdata);
            end
            checks++;
            if (im_done !== exp_i || dm_done !== exp_d || im_rdata !== (exp_i ? t_rdata : 32'h0) ||
                dm_rdata !== (exp_d ? t_rdata : 32'h0)) begin
                errors++;
                $display("FAIL rnd_done cyc=%0d: im=%b/%h dm=%b/%h want im=%b dm=%b data=%h", cyc, im_done, im_rdata, dm_done, dm_rdata, exp_i, exp_d, t_rdata);
            end
            if (exp_i) begin
                im_req = 1'($urandom_range(0, 1)); im_addr = 16'($urandom);
            end else if (!im_req && $urandom_range(0, 3) == 0) begin
                im_req = 1'b1; im_addr = 16'($urandom);
            end
            if (exp_d) begin
                dm_req = 1'($urandom_range(0, 1)); dm_we = 1'($urandom_range(0, 1));
                dm_addr = 16'($urandom); dm_wdata = $urandom;
            end else if (!dm_req && $urandom_range(0, 2) == 0) begin
                dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1));
                dm_addr = 16'($urandom); dm_wdata = $urandom;
            end
            if (ph == 0) begin
                if (im_req || dm_req) begin
                    if (im_req && (!dm_req || streak == MAX_D_STREAK)) begin
                        own_i = 1'b1; t_addr = im_addr; t_we = 1'b0; t_wdata = 32'h0;
                        t_rdata = mem_val(im_addr); streak = 0;
                    end else begin
                        own_i = 1'b0; t_addr = dm_addr; t_we = dm_we; t_wdata = dm_wdata;
                        t_rdata = dm_we ? 32'h0 : mem_val(dm_addr);
                        streak = im_req ? ((streak < MAX_D_STREAK) ? streak + 1 : MAX_D_STREAK) : 0;
                    end
                    ph = 1;
                end
            end else begin
                ph = (ph == MEM_LAT + 1) ? 0 : ph + 1;
            end
        end
        idle_inputs();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_simultaneous();
        test_starvation();
        test_reset_mid();
        test_late_request();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
